int_request_ctrl: RTL and testbench

//  Upstream feeder of the exception/vector stage: synchronises three external interrupt

---
 rtl/int_request_ctrl_pkg.sv | 32 +++
 rtl/int_request_ctrl_irq_sync.sv | 35 +++
 rtl/int_request_ctrl.sv | 97 +++++++++
 tb/tb_int_request_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/int_request_ctrl_pkg.sv
// Shared types for the interrupt request controller: FSM states, grant record
// and the lowest-index-first priority picker.
package int_ctrl_pkg;

    localparam int          NUM_SRC    = 3;
    localparam int          IDX_W      = 2;
    localparam logic [1:0]  IRQ_VEC_HI = 2'b00;

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_REL} state_t;

    typedef struct packed {
        logic               any;
        logic [IDX_W-1:0]   idx;
        logic [NUM_SRC-1:0] oh;
    } grant_t;

    // Lowest set bit wins; scanning downward lets the lowest index overwrite.
    function automatic grant_t onehot_lsb(input logic [NUM_SRC-1:0] req);
        grant_t g;
        g = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                g.any   = 1'b1;
                g.idx   = IDX_W'(i);
                g.oh    = '0;
                g.oh[i] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/int_request_ctrl_irq_sync.sv
// Per-source input synchroniser. Default build emits a one-cycle pulse on a
// synchronised rising edge; with IRQ_LEVEL_MODE_EN defined it emits the
// synchronised level instead.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic req
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the async line through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
    end

`ifdef IRQ_LEVEL_MODE_EN
    assign req = sync_q[SYNC_STAGES-1];
`else
    logic prev_q;

    // Remember the last synchronised value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= sync_q[SYNC_STAGES-1];
    end

    assign req = sync_q[SYNC_STAGES-1] & ~prev_q;
`endif

endmodule

// File: rtl/int_request_ctrl.sv
// Interrupt request controller: synchronise, latch pending, mask, pick the
// lowest enabled source, present it active-low on OINT and retire it on IACK.
// IRQ_LEVEL_MODE_EN: pending follows the synchronised level, ack does not clear.
module int_request_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int               N_SRC       = NUM_SRC,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0] MASK_RST    = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic [4:0]       vector,
    input  logic             IACK,
    output logic [N_SRC-1:0] OINT,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] irq_mask
);

    logic [N_SRC-1:0] req_w, pend_d, oint_d, g_oh;
    logic [IDX_W-1:0] g_q, g_d;
    state_t           state_q, state_d;
    grant_t           sel;
    logic             ack_hit;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [N_SRC-1:0] (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .req    (req_w)
    );

    assign sel     = onehot_lsb(pending & irq_mask);
    assign g_oh    = N_SRC'(1) << g_q;
    // Only an ack carrying our own vector retires the grant; any other vector
    // means a higher-priority exception is being served.
    assign ack_hit = !IACK && (vector == {IRQ_VEC_HI, g_oh});

    // Next state, grant capture, pending update and next OINT value.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        oint_d  = '1;
`ifdef IRQ_LEVEL_MODE_EN
        pend_d  = req_w;
`else
        pend_d  = pending | req_w;
`endif
        case (state_q)
            IDLE: begin
                if (sel.any) begin
                    state_d = ASSERT;
                    g_d     = sel.idx;
                    oint_d  = ~sel.oh;
                end
            end
            ASSERT: begin
                if (ack_hit) begin
                    state_d = WAIT_REL;
`ifndef IRQ_LEVEL_MODE_EN
                    // A fresh edge in the same cycle keeps the bit set.
                    pend_d  = (pending & ~g_oh) | req_w;
`endif
                end else if (!irq_mask[g_q]) begin
                    state_d = IDLE;
                end else begin
                    oint_d  = ~g_oh;
                end
            end
            WAIT_REL: begin
                if (IACK) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant, OINT, pending and mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            g_q      <= '0;
            OINT     <= '1;
            pending  <= '0;
            irq_mask <= MASK_RST;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            OINT     <= oint_d;
            pending  <= pend_d;
            if (mask_we) irq_mask <= mask_wdata;
        end
    end

endmodule

// File: tb/tb_int_request_ctrl.sv
// Table-driven bench for int_request_ctrl with a cycle scoreboard, plus a
// hand-written latency sequence and a mid-handshake reset.
module tb_int_request_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] irq_in = '0;
    logic       mask_we = 1'b0;
    logic [2:0] mask_wdata = '0;
    logic [4:0] vector = '0;
    logic       IACK = 1'b1;
    logic [2:0] OINT, pending, irq_mask;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [2:0] irq;
        logic       we;
        logic [2:0] wd;
        logic [4:0] vec;
        logic       iack;
        logic [2:0] oint;
        logic [2:0] pend;
        logic [2:0] mask;
    } row_t;

    typedef struct {
        int         id;
        logic [2:0] oint;
        logic [2:0] pend;
        logic [2:0] mask;
    } exp_t;

    row_t tbl[$];
    exp_t sb[$];

    int_request_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .vector     (vector),
        .IACK       (IACK),
        .OINT       (OINT),
        .pending    (pending),
        .irq_mask   (irq_mask)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [2:0] irq, input logic we,
                       input logic [2:0] wd, input logic [4:0] vec, input logic ack_n,
                       input logic [2:0] eo, input logic [2:0] ep, input logic [2:0] em);
        row_t t;
        t.rst = r; t.irq = irq; t.we = we; t.wd = wd; t.vec = vec; t.iack = ack_n;
        t.oint = eo; t.pend = ep; t.mask = em;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int id, input logic [2:0] act,
                       input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step%0d actual=%b expected=%b", name, id, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        int   cnt;
        // rst irq we wd vec iack | OINT pending mask
        add(1, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(1, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
`ifdef IRQ_LEVEL_MODE_EN
        // Level: held line is re-granted after release, dropped line is not.
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b010, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b101, 3'b010, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b010, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b010, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b010, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b101, 3'b010, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b010, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b010, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b000, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
`else
        // Single source: latency, ack, no re-grant while IACK low.
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b010, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b101, 3'b010, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b000, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b000, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b000, 3'b111);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        // Two simultaneous sources: bit1 first, then bit2.
        add(0, 3'b110, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b110, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b110, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b110, 3'b111);
        add(0, 3'b110, 0, 3'b000, 5'b00000, 1, 3'b101, 3'b110, 3'b111);
        add(0, 3'b110, 0, 3'b000, 5'b00010, 0, 3'b111, 3'b100, 3'b111);
        add(0, 3'b110, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b100, 3'b111);
        add(0, 3'b110, 0, 3'b000, 5'b00000, 1, 3'b011, 3'b100, 3'b111);
        add(0, 3'b110, 0, 3'b000, 5'b00100, 0, 3'b111, 3'b000, 3'b111);
        add(0, 3'b110, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        // Foreign vector ack is ignored, own vector retires.
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b110, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00101, 0, 3'b110, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00101, 0, 3'b110, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00001, 0, 3'b111, 3'b000, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        // Mask withdraw keeps pending; unmask re-grants.
        add(0, 3'b100, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b100, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b100, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b100, 3'b111);
        add(0, 3'b100, 0, 3'b000, 5'b00000, 1, 3'b011, 3'b100, 3'b111);
        add(0, 3'b100, 1, 3'b011, 5'b00000, 1, 3'b011, 3'b100, 3'b011);
        add(0, 3'b100, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b100, 3'b011);
        add(0, 3'b100, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b100, 3'b011);
        add(0, 3'b100, 1, 3'b111, 5'b00000, 1, 3'b111, 3'b100, 3'b111);
        add(0, 3'b100, 0, 3'b000, 5'b00000, 1, 3'b011, 3'b100, 3'b111);
        add(0, 3'b100, 0, 3'b000, 5'b00100, 0, 3'b111, 3'b000, 3'b111);
        add(0, 3'b100, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        // New edge in the ack cycle: set wins, re-grant after release.
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b001, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b110, 3'b001, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b110, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b110, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b110, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00001, 0, 3'b111, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b110, 3'b001, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00001, 0, 3'b111, 3'b000, 3'b111);
        add(0, 3'b001, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        // Reset mid-handshake discards the grant and restores the mask.
        add(0, 3'b010, 1, 3'b110, 5'b00000, 1, 3'b111, 3'b000, 3'b110);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b110);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b010, 3'b110);
        add(0, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b101, 3'b010, 3'b110);
        add(1, 3'b010, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
        add(0, 3'b000, 0, 3'b000, 5'b00000, 1, 3'b111, 3'b000, 3'b111);
`endif

        foreach (tbl[i]) begin
            exp_t x;
            @(negedge clk);
            rst = tbl[i].rst; irq_in = tbl[i].irq; mask_we = tbl[i].we;
            mask_wdata = tbl[i].wd; vector = tbl[i].vec; IACK = tbl[i].iack;
            x.id = i; x.oint = tbl[i].oint; x.pend = tbl[i].pend; x.mask = tbl[i].mask;
            sb.push_back(x);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk("oint", e.id, OINT, e.oint);
            chk("pending", e.id, pending, e.pend);
            chk("mask", e.id, irq_mask, e.mask);
        end

        // Edge-to-grant latency on source 2, bounded wait.
        @(negedge clk);
        rst = 1'b0; irq_in = 3'b100; mask_we = 1'b0; vector = '0; IACK = 1'b1;
        cnt = 0;
        while (cnt <= 10) begin
            @(posedge clk); #1;
            cnt++;
            if (OINT !== 3'b111) break;
        end
        chk("grant_latency", cnt, 3'(cnt), 3'd4);
        chk("grant_oint", cnt, OINT, 3'b011);
        @(negedge clk);
        vector = 5'b00100; IACK = 1'b0;
        @(posedge clk); #1;
        chk("ack_oint", 0, OINT, 3'b111);
`ifdef IRQ_LEVEL_MODE_EN
        chk("ack_pending", 0, pending, 3'b100);
`else
        chk("ack_pending", 0, pending, 3'b000);
`endif
        @(negedge clk);
        rst = 1'b1; irq_in = '0; vector = '0; IACK = 1'b1;
        @(posedge clk); #1;
        chk("final_rst_oint", 0, OINT, 3'b111);
        chk("final_rst_pending", 0, pending, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
